vdp_ctrl_port: RTL and testbench

//  Parametrised VDP bus-side front end. Decodes Z80 I/O cycles to the data and control ports and runs the
//  two-byte control-word sequencer (address/code latch). Drives register-file writes, auto-incrementing

---
 rtl/vdp_ctrl_port.sv | 192 +++++++++++++++++++
 tb/tb_vdp_ctrl_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_ctrl_port.sv
// VDP bus-side front end: Z80 I/O decode, two-byte control-word sequencer,
// register-file writes, auto-incrementing VRAM/CRAM access and read-ahead buffer.
module vdp_ctrl_port #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] PORT_BASE = 8'hBE,
    parameter logic [ADDR_W-1:0] PORT_MASK = 8'hFE,
    parameter int                VADDR_W   = 14,
    parameter int                CRAM_AW   = 5,
    parameter int                NUM_REGS  = 11,
    parameter int                HOLD_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic [7:0]         data_in,
    input  logic               IORQ_L,
    input  logic               RD_L,
    input  logic               WR_L,
    output logic [7:0]         data_out,
    output logic               data_oe,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic               rf_we,
    output logic [3:0]         rf_addr,
    output logic [7:0]         rf_data,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_cram,
    output logic [VADDR_W-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic               overrun
);

    localparam int                 CNT_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [VADDR_W-1:0] CRAM_MASK  = VADDR_W'((64'd1 << CRAM_AW) - 64'd1);
    localparam logic [4:0]         NUM_REGS_C = 5'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               first_r;
    logic [7:0]         latch_r;
    logic [1:0]         code_r;
    logic [VADDR_W-1:0] addr_r;
    logic [7:0]         rdbuf_r;

    logic               hit_s;
    logic               entry_s;
    logic               hold_done_s;
    logic               is_wr_s;
    logic               is_ctrl_s;
    logic               ctrl_wr1_s;
    logic               ctrl_wr2_s;
    logic               ctrl_rd_s;
    logic               data_wr_s;
    logic               data_rd_s;
    logic               code0_s;
    logic               want_mem_s;
    logic               issue_s;
    logic               drop_s;
    logic [VADDR_W-1:0] ctrl_addr_s;
    logic [VADDR_W-1:0] wr_addr_s;

    assign hit_s       = ~IORQ_L & (~RD_L | ~WR_L) &
                         ((addr_in & PORT_MASK) == (PORT_BASE & PORT_MASK));
    assign entry_s     = (state_r == ST_IDLE) & hit_s;
    assign hold_done_s = (cnt_r == CNT_W'(HOLD_CYC - 1));
    assign is_wr_s     = ~WR_L;
    assign is_ctrl_s   = addr_in[0];

    assign ctrl_wr1_s  = entry_s &  is_ctrl_s &  is_wr_s & ~first_r;
    assign ctrl_wr2_s  = entry_s &  is_ctrl_s &  is_wr_s &  first_r;
    assign ctrl_rd_s   = entry_s &  is_ctrl_s & ~is_wr_s;
    assign data_wr_s   = entry_s & ~is_ctrl_s &  is_wr_s;
    assign data_rd_s   = entry_s & ~is_ctrl_s & ~is_wr_s;

    // Only one request may be outstanding; a second one is dropped and flagged.
    assign code0_s     = ctrl_wr2_s & (data_in[7:6] == 2'd0);
    assign want_mem_s  = data_wr_s | data_rd_s | code0_s;
    assign issue_s     = want_mem_s & ~mem_req;
    assign drop_s      = want_mem_s &  mem_req;

    assign ctrl_addr_s = VADDR_W'({data_in[5:0], latch_r});
    assign wr_addr_s   = (code_r == 2'd3) ? (addr_r & CRAM_MASK) : addr_r;

    // Bus FSM next-state: one side effect per Z80 cycle, re-armed only once IORQ_L rises.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) state_nxt_s = ST_ACCESS;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (hold_done_s) state_nxt_s = ST_RELEASE;
                else             state_nxt_s = ST_ACCESS;
            end
            ST_RELEASE: begin
                if (IORQ_L) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_RELEASE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus FSM state register and ACCESS hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_ACCESS) cnt_r <= cnt_r + CNT_W'(1);
            else                      cnt_r <= '0;
        end
    end

    // Sequencer, memory handshake and bus read-back registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_r   <= 1'b0;
            latch_r   <= 8'h00;
            code_r    <= 2'd0;
            addr_r    <= '0;
            rdbuf_r   <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            status_rd <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr   <= 4'h0;
            rf_data   <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_cram  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            rf_we     <= 1'b0;
            status_rd <= ctrl_rd_s;

            if (ctrl_wr1_s) begin
                latch_r <= data_in;
                first_r <= 1'b1;
            end else if (entry_s) begin
                first_r <= 1'b0;
            end

            if (ctrl_wr2_s && !drop_s) begin
                code_r  <= data_in[7:6];
                addr_r  <= code0_s ? ctrl_addr_s + VADDR_W'(1) : ctrl_addr_s;
                rf_we   <= (data_in[7:6] == 2'd2) && ({1'b0, data_in[3:0]} < NUM_REGS_C);
                rf_addr <= data_in[3:0];
                rf_data <= latch_r;
            end else if (issue_s) begin
                addr_r  <= addr_r + VADDR_W'(1);
            end

            // Address advances at issue time, so mem_addr holds the pre-increment value.
            if (issue_s) begin
                mem_req   <= 1'b1;
                mem_we    <= data_wr_s;
                mem_cram  <= data_wr_s & (code_r == 2'd3);
                mem_addr  <= code0_s ? ctrl_addr_s : (data_wr_s ? wr_addr_s : addr_r);
                mem_wdata <= data_wr_s ? data_in : 8'h00;
                if (data_wr_s) rdbuf_r <= data_in;
            end else if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) rdbuf_r <= mem_rdata;
            end

            if (drop_s) overrun <= 1'b1;

            if (entry_s && !is_wr_s) begin
                data_oe  <= 1'b1;
                data_out <= is_ctrl_s ? status_in : rdbuf_r;
            end else if ((state_r == ST_RELEASE) && IORQ_L) begin
                data_oe  <= 1'b0;
                data_out <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_vdp_ctrl_port.sv
// Bench for vdp_ctrl_port: directed scenarios plus a randomized run against
// a transaction-level model of the control/data port behaviour.
module tb_vdp_ctrl_port;

    typedef struct packed {
        logic        we;
        logic        cram;
        logic [13:0] addr;
        logic [7:0]  d;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_in;
    logic [7:0]  data_in;
    logic        IORQ_L, RD_L, WR_L;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  status_in;
    logic        status_rd;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_data;
    logic        mem_req, mem_we, mem_cram;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        overrun;

    logic [48:0] outs;
    assign outs = {data_out, data_oe, status_rd, rf_we, rf_addr, rf_data,
                   mem_req, mem_we, mem_cram, mem_addr, mem_wdata, overrun};

    int          checks;
    int          failures;
    bit          ack_en;
    int          ack_wait = 0;
    int          status_cnt = 0;
    logic [7:0]  rv;
    logic        rv_oe;
    logic [7:0]  vram [0:16383];
    logic [7:0]  cram [0:31];
    txn_t        got_q[$];
    txn_t        exp_q[$];
    logic [11:0] rf_log[$];
    logic [11:0] exp_rf[$];

    // reference model state
    bit          m_first;
    logic [7:0]  m_latch;
    logic [1:0]  m_code;
    logic [13:0] m_addr;
    logic [7:0]  m_rdbuf;

    vdp_ctrl_port dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .data_out(data_out), .data_oe(data_oe),
        .status_in(status_in), .status_rd(status_rd),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_cram(mem_cram),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after a random delay and logs every completed transaction.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && ack_en) begin
            if (ack_wait > 0) begin
                ack_wait--;
            end else begin
                mem_rdata = vram[mem_addr];
                mem_ack   = 1'b1;
                got_q.push_back({mem_we, mem_cram, mem_addr, mem_we ? mem_wdata : 8'h00});
                if (mem_we && mem_cram) cram[mem_addr[4:0]] = mem_wdata;
                else if (mem_we)        vram[mem_addr] = mem_wdata;
                ack_wait = $urandom_range(0, 3);
            end
        end
    end

    // Register-write and status-read monitor.
    always @(negedge clk) begin
        if (rf_we)     rf_log.push_back({rf_addr, rf_data});
        if (status_rd) status_cnt++;
    end

    task automatic bus_cycle(input bit port, input bit wr, input logic [7:0] d, input int hold);
        int n;
        @(negedge clk);
        addr_in = {7'h5F, port};
        data_in = d;
        IORQ_L  = 1'b0;
        WR_L    = !wr;
        RD_L    = wr;
        repeat (hold) @(negedge clk);
        rv      = data_out;
        rv_oe   = data_oe;
        IORQ_L  = 1'b1;
        WR_L    = 1'b1;
        RD_L    = 1'b1;
        addr_in = 8'($urandom);
        data_in = 8'($urandom);
        repeat (2) @(negedge clk);
        if (ack_en) begin
            n = 0;
            while (mem_req && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (mem_req !== 1'b0) begin
                failures++;
                $display("FAIL mem_ack_wait got mem_req=%b exp=0", mem_req);
            end
        end
    endtask

    task automatic ctrl_wr(input logic [7:0] d); bus_cycle(1'b1, 1'b1, d, $urandom_range(3, 6)); endtask
    task automatic data_wr(input logic [7:0] d); bus_cycle(1'b0, 1'b1, d, $urandom_range(3, 6)); endtask
    task automatic data_rd();                    bus_cycle(1'b0, 1'b0, 8'h00, $urandom_range(3, 6)); endtask
    task automatic ctrl_rd();                    bus_cycle(1'b1, 1'b0, 8'h00, $urandom_range(3, 6)); endtask

    // Model: a memory access recorded as the transaction the port must emit.
    task automatic m_issue(input bit we, input logic [7:0] d);
        bit cram_t;
        cram_t = we && (m_code == 2'd3);
        exp_q.push_back({we, cram_t, cram_t ? (m_addr % 14'd32) : m_addr, we ? d : 8'h00});
        m_rdbuf = we ? d : vram[m_addr];
        m_addr  = m_addr + 14'd1;
    endtask

    task automatic m_ctrl_write(input logic [7:0] d);
        if (!m_first) begin
            m_latch = d;
            m_first = 1'b1;
        end else begin
            m_first = 1'b0;
            m_code  = d[7:6];
            m_addr  = {d[5:0], m_latch};
            if (m_code == 2'd2 && d[3:0] < 4'd11) exp_rf.push_back({d[3:0], m_latch});
            if (m_code == 2'd0) m_issue(1'b0, 8'h00);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== 49'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        rst    = 1'b0;
        ack_en = 1'b0;
        ctrl_wr(8'h00); ctrl_wr(8'h40); data_wr(8'h5A); ctrl_wr(8'h77);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL pending_req got=%b exp=1", mem_req); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== 49'd0) begin failures++; $display("FAIL reset_mid_req got=%h exp=0", outs); end
        rst    = 1'b0;
        ack_en = 1'b1;
        got_q.delete();
        rf_log.delete();
        ctrl_wr(8'h15); ctrl_wr(8'h81);
        checks++;
        if (rf_log.size() != 1) begin
            failures++; $display("FAIL first_after_reset got=%0d writes exp=1", rf_log.size());
        end else if (rf_log[0] !== 12'h115) begin
            failures++; $display("FAIL first_after_reset got=%h exp=115", rf_log[0]);
        end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL reset_no_mem got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_reg_write();
        int s0;
        got_q.delete();
        rf_log.delete();
        s0 = status_cnt;
        ctrl_wr(8'hA5); ctrl_wr(8'h8A);
        ctrl_wr(8'h00); ctrl_wr(8'h8F);
        ctrl_wr(8'h33); ctrl_wr(8'h8B);
        status_in = 8'hC3;
        ctrl_wr(8'h3C); ctrl_rd();
        checks++;
        if (rv !== 8'hC3 || rv_oe !== 1'b1) begin
            failures++; $display("FAIL status_read got=%h oe=%b exp=c3 oe=1", rv, rv_oe);
        end
        ctrl_wr(8'h82); ctrl_wr(8'h80);
        checks++;
        if (status_cnt - s0 != 1) begin failures++; $display("FAIL status_rd_pulse got=%0d exp=1", status_cnt - s0); end
        checks++;
        if (rf_log.size() != 2) begin
            failures++; $display("FAIL reg_write_count got=%0d exp=2", rf_log.size());
        end else if (rf_log[0] !== 12'hAA5 || rf_log[1] !== 12'h082) begin
            failures++; $display("FAIL reg_write_data got=%h,%h exp=aa5,082", rf_log[0], rf_log[1]);
        end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL reg_no_mem got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_vram_burst();
        got_q.delete();
        ctrl_wr(8'hFE); ctrl_wr(8'h7F);
        data_wr(8'hAA); data_wr(8'hBB); data_wr(8'hCC);
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL burst_count got=%0d exp=3", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {1'b1, 1'b0, 14'h3FFE, 8'hAA}) begin failures++; $display("FAIL burst_w0 got=%h exp=%h", got_q[0], {1'b1, 1'b0, 14'h3FFE, 8'hAA}); end
            checks++;
            if (got_q[1] !== {1'b1, 1'b0, 14'h3FFF, 8'hBB}) begin failures++; $display("FAIL burst_w1 got=%h exp=%h", got_q[1], {1'b1, 1'b0, 14'h3FFF, 8'hBB}); end
            checks++;
            if (got_q[2] !== {1'b1, 1'b0, 14'h0000, 8'hCC}) begin failures++; $display("FAIL burst_wrap got=%h exp=%h", got_q[2], {1'b1, 1'b0, 14'h0000, 8'hCC}); end
        end
    endtask

    task automatic test_read_ahead();
        got_q.delete();
        vram[14'h0100] = 8'h11;
        vram[14'h0101] = 8'h22;
        ctrl_wr(8'h00); ctrl_wr(8'h01);
        data_rd();
        checks++;
        if (rv !== 8'h11 || rv_oe !== 1'b1) begin failures++; $display("FAIL read_ahead_1 got=%h oe=%b exp=11 oe=1", rv, rv_oe); end
        data_rd();
        checks++;
        if (rv !== 8'h22) begin failures++; $display("FAIL read_ahead_2 got=%h exp=22", rv); end
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL read_count got=%0d exp=3", got_q.size());
        end else if (got_q[0] !== {2'b00, 14'h0100, 8'h00} || got_q[1] !== {2'b00, 14'h0101, 8'h00}) begin
            failures++; $display("FAIL read_addrs got=%h,%h exp=010000,010100", got_q[0], got_q[1]);
        end
    endtask

    task automatic test_cram_first();
        got_q.delete();
        ctrl_wr(8'h05); data_rd();
        ctrl_wr(8'h03); ctrl_wr(8'hC0); data_wr(8'h3F);
        ctrl_wr(8'h03); ctrl_wr(8'hC0); data_wr(8'h3F);
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL cram_count got=%0d exp=3", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {2'b00, 14'h0103, 8'h00}) begin failures++; $display("FAIL first_clear_read got=%h exp=%h", got_q[0], {2'b00, 14'h0103, 8'h00}); end
            checks++;
            if (got_q[1] !== {2'b11, 14'h0003, 8'h3F} || got_q[2] !== {2'b11, 14'h0003, 8'h3F}) begin
                failures++; $display("FAIL cram_write got=%h,%h exp=%h", got_q[1], got_q[2], {2'b11, 14'h0003, 8'h3F});
            end
        end
    endtask

    task automatic test_overrun_hold();
        int n;
        got_q.delete();
        ctrl_wr(8'h00); ctrl_wr(8'h50);
        ack_en = 1'b0;
        data_wr(8'h12); data_wr(8'h34);
        checks++;
        if (overrun !== 1'b1 || mem_req !== 1'b1 || mem_wdata !== 8'h12 || mem_addr !== 14'h1000) begin
            failures++; $display("FAIL overrun_drop got=ovr%b req%b %h@%h exp=ovr1 req1 12@1000", overrun, mem_req, mem_wdata, mem_addr);
        end
        ack_en = 1'b1;
        n = 0;
        while (mem_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL overrun_drain got=%b exp=0", mem_req); end
        bus_cycle(1'b0, 1'b1, 8'h56, 10);
        checks++;
        if (got_q.size() != 2) begin
            failures++; $display("FAIL hold_count got=%0d exp=2", got_q.size());
        end else if (got_q[0] !== {2'b10, 14'h1000, 8'h12} || got_q[1] !== {2'b10, 14'h1001, 8'h56}) begin
            failures++; $display("FAIL hold_txns got=%h,%h exp=%h,%h", got_q[0], got_q[1], {2'b10, 14'h1000, 8'h12}, {2'b10, 14'h1001, 8'h56});
        end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_random();
        int         op;
        int         s0;
        int         exp_status;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_first = 1'b0; m_latch = 8'h00; m_code = 2'd0; m_addr = 14'h0000; m_rdbuf = 8'h00;
        got_q.delete(); exp_q.delete(); rf_log.delete(); exp_rf.delete();
        s0 = status_cnt;
        exp_status = 0;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if (op <= 3) begin
                if (m_first && $urandom_range(0, 1) == 1) d[7:6] = 2'd2;
                ctrl_wr(d);
                m_ctrl_write(d);
            end else if (op <= 5) begin
                data_wr(d);
                m_first = 1'b0;
                m_issue(1'b1, d);
            end else if (op <= 7) begin
                data_rd();
                m_first = 1'b0;
                e = m_rdbuf;
                m_issue(1'b0, 8'h00);
                checks++;
                if (rv !== e) begin failures++; $display("FAIL rand_data_read[%0d] got=%h exp=%h", i, rv, e); end
            end else begin
                status_in = d;
                ctrl_rd();
                m_first = 1'b0;
                exp_status++;
                checks++;
                if (rv !== d) begin failures++; $display("FAIL rand_status[%0d] got=%h exp=%h", i, rv, d); end
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_txn_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL rand_txn[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
        checks++;
        if (rf_log.size() != exp_rf.size()) begin
            failures++; $display("FAIL rand_rf_count got=%0d exp=%0d", rf_log.size(), exp_rf.size());
        end else begin
            foreach (exp_rf[k]) begin
                checks++;
                if (rf_log[k] !== exp_rf[k]) begin failures++; $display("FAIL rand_rf[%0d] got=%h exp=%h", k, rf_log[k], exp_rf[k]); end
            end
        end
        checks++;
        if (status_cnt - s0 != exp_status) begin failures++; $display("FAIL rand_status_cnt got=%0d exp=%0d", status_cnt - s0, exp_status); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun got=%b exp=0", overrun); end
    endtask

    initial begin
        rst       = 1'b1;
        IORQ_L    = 1'b1;
        RD_L      = 1'b1;
        WR_L      = 1'b1;
        addr_in   = 8'h00;
        data_in   = 8'h00;
        status_in = 8'h00;
        ack_en    = 1'b1;
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 32; i++)    cram[i] = 8'h00;
        test_reset();
        test_reg_write();
        test_vram_burst();
        test_read_ahead();
        test_cram_first();
        test_overrun_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule
